// File: rtl/sram_resp_if.sv
// SRAM-style request/response bundle between the core (master) and memory (slave).
interface sram_resp_if;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
   modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_resp.sv
// Single-outstanding SRAM responder: byte-write word array answering each accepted
// request after a fixed LATENCY with a one-cycle data_ok pulse.
//
// state | meaning
// IDLE  | no request outstanding, may accept
// WAIT  | request accepted, counting down to the response
// RESP  | data_ok cycle, may accept the next request back-to-back
module sram_resp #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        resetn,
   sram_resp_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       rdata_q;
   logic              can_accept;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       mem [2**ADDR_W];

   assign idx        = bus.addr[ADDR_W+1:2];
   assign can_accept = bus.req & ((state_q == IDLE) | (state_q == RESP));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (can_accept & ~bus.wr) rdata_q <= mem[idx];
      end
   end

   // Array has no reset so it maps onto byte-enabled block RAM.
   always_ff @(posedge clk) begin
      if (can_accept & bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (can_accept) begin
         cnt_d   = CNT_INIT;
         state_d = (LATENCY == 1) ? RESP : WAIT;
      end else begin
         case (state_q)
            WAIT: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.addr_ok = can_accept & resetn;
      bus.data_ok = (state_q == RESP);
      bus.rdata   = rdata_q;
   end
endmodule

// File: tb/tb_sram_resp.sv
// Directed bench: four responders (LATENCY 1..4) share one stimulus bus and reset.
module tb_sram_resp;
   logic        clk;
   logic        resetn;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;

   int checks = 0;
   int passed = 0;
   int viol_cnt = 0;

   sram_resp_if bif1 ();
   sram_resp_if bif2 ();
   sram_resp_if bif3 ();
   sram_resp_if bif4 ();

   assign bif1.req = req; assign bif1.wr = wr; assign bif1.wstrb = wstrb; assign bif1.addr = addr; assign bif1.wdata = wdata;
   assign bif2.req = req; assign bif2.wr = wr; assign bif2.wstrb = wstrb; assign bif2.addr = addr; assign bif2.wdata = wdata;
   assign bif3.req = req; assign bif3.wr = wr; assign bif3.wstrb = wstrb; assign bif3.addr = addr; assign bif3.wdata = wdata;
   assign bif4.req = req; assign bif4.wr = wr; assign bif4.wstrb = wstrb; assign bif4.addr = addr; assign bif4.wdata = wdata;

   sram_resp #(.ADDR_W(10), .LATENCY(1)) u_l1 (.clk(clk), .resetn(resetn), .bus(bif1));
   sram_resp #(.ADDR_W(10), .LATENCY(2)) u_l2 (.clk(clk), .resetn(resetn), .bus(bif2));
   sram_resp #(.ADDR_W(10), .LATENCY(3)) u_l3 (.clk(clk), .resetn(resetn), .bus(bif3));
   sram_resp #(.ADDR_W(10), .LATENCY(4)) u_l4 (.clk(clk), .resetn(resetn), .bus(bif4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Protocol monitor: data_ok spacing and outstanding-request balance per instance.
   logic [3:0] aok, dok, prev_aok, prev_dok;
   int         outst [4];
   int         lat [4] = '{1, 2, 3, 4};
   assign aok = {bif4.addr_ok, bif3.addr_ok, bif2.addr_ok, bif1.addr_ok};
   assign dok = {bif4.data_ok, bif3.data_ok, bif2.data_ok, bif1.data_ok};

   always @(negedge clk) begin
      if (!resetn) begin
         prev_aok = '0;
         prev_dok = '0;
         for (int i = 0; i < 4; i++) outst[i] = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (dok[i] && prev_dok[i] && !(prev_aok[i] && lat[i] == 1)) viol_cnt++;
            outst[i] = outst[i] + int'(aok[i]) - int'(dok[i]);
            if (outst[i] < 0 || outst[i] > 1) viol_cnt++;
         end
         prev_aok = aok;
         prev_dok = dok;
      end
   end

   task automatic drain();
      req = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b1; addr = a; wdata = d; wstrb = s;
      @(posedge clk); #1;
      req = 1'b0; wr = 1'b0;
      drain();
   endtask

   task automatic test_reset();
      resetn = 1'b0; req = 1'b1; wr = 1'b0; wstrb = 4'h0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (bif2.addr_ok !== 1'b0) $display("FAIL reset_addr_ok got=%b exp=0", bif2.addr_ok); else passed++;
      checks++; if (bif2.data_ok !== 1'b0) $display("FAIL reset_data_ok got=%b exp=0", bif2.data_ok); else passed++;
      checks++; if (bif2.rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bif2.rdata); else passed++;
      checks++; if (bif1.addr_ok !== 1'b0) $display("FAIL reset_addr_ok_l1 got=%b exp=0", bif1.addr_ok); else passed++;
      @(posedge clk); #1;
      req = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      checks++; if (bif2.addr_ok !== 1'b0) $display("FAIL idle_addr_ok got=%b exp=0", bif2.addr_ok); else passed++;
      checks++; if (bif2.data_ok !== 1'b0) $display("FAIL idle_data_ok got=%b exp=0", bif2.data_ok); else passed++;
   endtask

   task automatic test_lat2();
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b1; addr = 32'h1C00_0010; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      @(negedge clk);
      checks++; if (bif2.addr_ok !== 1'b1) $display("FAIL l2_wr_accept got=%b exp=1", bif2.addr_ok); else passed++;
      @(posedge clk); #1;
      req = 1'b0; wr = 1'b0;
      @(negedge clk);
      checks++; if (bif2.data_ok !== 1'b0) $display("FAIL l2_wr_t1_data_ok got=%b exp=0", bif2.data_ok); else passed++;
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; addr = 32'h1C00_0010;
      @(negedge clk);
      checks++; if (bif2.data_ok !== 1'b1) $display("FAIL l2_wr_t2_data_ok got=%b exp=1", bif2.data_ok); else passed++;
      checks++; if (bif2.addr_ok !== 1'b1) $display("FAIL l2_b2b_accept got=%b exp=1", bif2.addr_ok); else passed++;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      checks++; if (bif2.data_ok !== 1'b0) $display("FAIL l2_rd_t3_data_ok got=%b exp=0", bif2.data_ok); else passed++;
      @(negedge clk);
      checks++; if (bif2.data_ok !== 1'b1) $display("FAIL l2_rd_t4_data_ok got=%b exp=1", bif2.data_ok); else passed++;
      checks++; if (bif2.rdata !== 32'hDEAD_BEEF) $display("FAIL l2_rd_rdata got=%h exp=deadbeef", bif2.rdata); else passed++;
      @(negedge clk);
      checks++; if (bif2.data_ok !== 1'b0) $display("FAIL l2_rd_t5_data_ok got=%b exp=0", bif2.data_ok); else passed++;
      drain();
   endtask

   task automatic test_alias();
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; addr = 32'hFFFF_F013;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      checks++; if (bif1.data_ok !== 1'b1) $display("FAIL alias_data_ok got=%b exp=1", bif1.data_ok); else passed++;
      checks++; if (bif1.rdata !== 32'hDEAD_BEEF) $display("FAIL alias_rdata got=%h exp=deadbeef", bif1.rdata); else passed++;
      drain();
   endtask

   task automatic test_strobe();
      bus_write(32'h20, 32'h1122_3344, 4'hF);
      bus_write(32'h20, 32'hAABB_CCDD, 4'b0101);
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF; wstrb = 4'h0;
      @(posedge clk); #1;
      req = 1'b0; wr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bif2.data_ok !== 1'b1) $display("FAIL strobe0_data_ok got=%b exp=1", bif2.data_ok); else passed++;
      drain();
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; addr = 32'h20;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bif2.data_ok !== 1'b1) $display("FAIL strobe_rd_data_ok got=%b exp=1", bif2.data_ok); else passed++;
      checks++; if (bif2.rdata !== 32'h11BB_33DD) $display("FAIL strobe_rdata got=%h exp=11bb33dd", bif2.rdata); else passed++;
      drain();
   endtask

   task automatic test_stream();
      logic [31:0] exp_rd [3];
      exp_rd = '{32'd1, 32'd2, 32'd3};
      bus_write(32'h0, 32'd1, 4'hF);
      bus_write(32'h4, 32'd2, 4'hF);
      bus_write(32'h8, 32'd3, 4'hF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         req = (i < 3); wr = 1'b0; addr = 32'(i * 4);
         @(negedge clk);
         if (i < 3) begin
            checks++; if (bif1.addr_ok !== 1'b1) $display("FAIL stream_addr_ok[%0d] got=%b exp=1", i, bif1.addr_ok); else passed++;
         end
         if (i >= 1 && i <= 3) begin
            checks++; if (bif1.data_ok !== 1'b1) $display("FAIL stream_data_ok[%0d] got=%b exp=1", i, bif1.data_ok); else passed++;
            checks++; if (bif1.rdata !== exp_rd[i-1]) $display("FAIL stream_rdata[%0d] got=%h exp=%h", i, bif1.rdata, exp_rd[i-1]); else passed++;
         end else begin
            checks++; if (bif1.data_ok !== 1'b0) $display("FAIL stream_data_ok[%0d] got=%b exp=0", i, bif1.data_ok); else passed++;
         end
      end
      drain();
   endtask

   task automatic test_stall();
      bus_write(32'h100, 32'hCAFE_0001, 4'hF);
      bus_write(32'h104, 32'hCAFE_0002, 4'hF);
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; addr = 32'h100;
      @(negedge clk);
      checks++; if (bif4.addr_ok !== 1'b1) $display("FAIL stall_accept got=%b exp=1", bif4.addr_ok); else passed++;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         addr = 32'h104 + 32'(k * 4);
         if (k == 1) addr = 32'h104;
         @(negedge clk);
         checks++; if (bif4.addr_ok !== 1'b0) $display("FAIL stall_addr_ok[%0d] got=%b exp=0", k, bif4.addr_ok); else passed++;
         checks++; if (bif4.data_ok !== 1'b0) $display("FAIL stall_data_ok[%0d] got=%b exp=0", k, bif4.data_ok); else passed++;
      end
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      checks++; if (bif4.data_ok !== 1'b1) $display("FAIL stall_t4_data_ok got=%b exp=1", bif4.data_ok); else passed++;
      checks++; if (bif4.rdata !== 32'hCAFE_0001) $display("FAIL stall_rdata got=%h exp=cafe0001", bif4.rdata); else passed++;
      for (int k = 5; k <= 8; k++) begin
         @(negedge clk);
         checks++; if (bif4.data_ok !== 1'b0) $display("FAIL stall_after_data_ok[%0d] got=%b exp=0", k, bif4.data_ok); else passed++;
      end
      drain();
   endtask

   task automatic test_reset_mid();
      bus_write(32'h40, 32'h5A5A_5A5A, 4'hF);
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; addr = 32'h44;
      @(negedge clk);
      checks++; if (bif3.addr_ok !== 1'b1) $display("FAIL rmid_accept got=%b exp=1", bif3.addr_ok); else passed++;
      @(posedge clk); #1;
      req = 1'b0;
      resetn = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++; if (bif3.data_ok !== 1'b0) $display("FAIL rmid_data_ok[%0d] got=%b exp=0", k, bif3.data_ok); else passed++;
      end
      checks++; if (bif3.rdata !== 32'h0) $display("FAIL rmid_rdata_reset got=%h exp=0", bif3.rdata); else passed++;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      checks++; if (bif3.data_ok !== 1'b0) $display("FAIL rmid_post_data_ok got=%b exp=0", bif3.data_ok); else passed++;
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; addr = 32'h40;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++; if (bif3.data_ok !== 1'b1) $display("FAIL rmid_rd_data_ok got=%b exp=1", bif3.data_ok); else passed++;
      checks++; if (bif3.rdata !== 32'h5A5A_5A5A) $display("FAIL rmid_rd_rdata got=%h exp=5a5a5a5a", bif3.rdata); else passed++;
      drain();
   endtask

   task automatic test_protocol();
      checks++; if (viol_cnt !== 0) $display("FAIL protocol_violations got=%0d exp=0", viol_cnt); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++; if (outst[i] !== 0) $display("FAIL outstanding[%0d] got=%0d exp=0", i, outst[i]); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_lat2();
      test_alias();
      test_strobe();
      test_stream();
      test_stall();
      test_reset_mid();
      test_protocol();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
